udma_ctrl_gen: RTL and testbench

- Parametrised next-generation uDMA global control block.
- Per-peripheral clock-gate and soft-reset control for NB_PERIPH peripherals; soft reset is a self-timing pulse of RST_CYCLES.
- NB_EVT programmable event comparators, each with enable, sticky status (write-1-to-clear) and a summary interrupt.
- Filter start/busy/done handshake. Sits between the APB-side cfg bus and the uDMA core/filter.

---
 rtl/udma_ctrl_gen.sv | 171 +++++++++++++++++
 tb/tb_udma_ctrl_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_ctrl_gen.sv
// udma_ctrl_gen: global control block for the uDMA subsystem.
//   - Per-peripheral clock-gate enables and self-timed soft-reset pulses.
//   - NB_EVT event comparators with enable, sticky W1C status and summary irq.
//   - Filter start/busy/done handshake (two-state FSM).
// Ports:
//   clk_i, rstn_i                  clock, async active-low reset
//   cfg_*                          word-addressed cfg bus, combinational reads, always ready
//   cg_value_o, cg_core_o          clock-gate enables and their OR
//   rst_value_o                    active-high soft-reset mask
//   filter_mode_o/start_o/busy_o   filter control, filter_done_i ends a run
//   event_valid_i, event_data_i    incoming event strobe and id, always ready
//   event_o, evt_irq_o             registered match pulses, OR of sticky status
module udma_ctrl_gen #(
    parameter int unsigned NB_PERIPH  = 16,
    parameter int unsigned NB_EVT     = 4,
    parameter int unsigned RST_CYCLES = 8,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [31:0]          cfg_data_i,
    input  logic [4:0]           cfg_addr_i,
    input  logic                 cfg_valid_i,
    input  logic                 cfg_rwn_i,
    output logic [31:0]          cfg_data_o,
    output logic                 cfg_ready_o,
    output logic [NB_PERIPH-1:0] cg_value_o,
    output logic                 cg_core_o,
    output logic [NB_PERIPH-1:0] rst_value_o,
    output logic [2:0]           filter_mode_o,
    output logic                 filter_start_o,
    output logic                 filter_busy_o,
    input  logic                 filter_done_i,
    input  logic                 event_valid_i,
    input  logic [7:0]           event_data_i,
    output logic                 event_ready_o,
    output logic [NB_EVT-1:0]    event_o,
    output logic                 evt_irq_o
);

    localparam logic [4:0] AddrCg      = 5'h00;
    localparam logic [4:0] AddrCfgEvt  = 5'h01;
    localparam logic [4:0] AddrRst     = 5'h02;
    localparam logic [4:0] AddrEvtEn   = 5'h03;
    localparam logic [4:0] AddrEvtStat = 5'h04;
    localparam logic [4:0] AddrFiltCmd = 5'h05;
    localparam logic [4:0] AddrFiltMode = 5'h06;

    typedef enum logic {StIdle, StBusy} filt_state_e;

    logic [NB_PERIPH-1:0]   r_cg;
    logic [NB_EVT-1:0][7:0] r_cmp;
    logic [NB_PERIPH-1:0]   r_rst;
    logic [CNT_W-1:0]       r_cnt;
    logic [NB_EVT-1:0]      r_evt_en;
    logic [NB_EVT-1:0]      r_status;
    logic [NB_EVT-1:0]      r_event;
    logic [2:0]             r_filt_mode;
    logic                   r_start;
    filt_state_e            r_state;

    logic                   w_wr;
    logic [NB_PERIPH-1:0]   w_rst_mask;
    logic [NB_EVT-1:0]      w_hit;
    logic [NB_EVT-1:0]      w_clr;
    logic                   w_start;
    filt_state_e            w_state_next;
    logic [31:0]            w_rdata;

    assign w_wr       = cfg_valid_i & ~cfg_rwn_i;
    assign w_rst_mask = cfg_data_i[NB_PERIPH-1:0];
    assign w_clr      = (w_wr && cfg_addr_i == AddrEvtStat) ? cfg_data_i[NB_EVT-1:0] : '0;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < int'(NB_EVT); i++) begin
            w_hit[i] = event_valid_i & r_evt_en[i] & (event_data_i == r_cmp[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cg        <= '0;
            r_cmp       <= '0;
            r_rst       <= '0;
            r_cnt       <= '0;
            r_evt_en    <= '0;
            r_status    <= '0;
            r_event     <= '0;
            r_filt_mode <= '0;
        end else begin
            if (w_wr && cfg_addr_i == AddrCg)       r_cg        <= cfg_data_i[NB_PERIPH-1:0];
            if (w_wr && cfg_addr_i == AddrEvtEn)    r_evt_en    <= cfg_data_i[NB_EVT-1:0];
            if (w_wr && cfg_addr_i == AddrFiltMode) r_filt_mode <= cfg_data_i[2:0];
            if (w_wr && cfg_addr_i == AddrCfgEvt) begin
                for (int i = 0; i < int'(NB_EVT); i++) begin
                    r_cmp[i] <= cfg_data_i[8*i +: 8];
                end
            end
            // A new hit overrides a simultaneous clear of the same bit.
            r_status <= (r_status & ~w_clr) | w_hit;
            r_event  <= w_hit;
            // Reload on every nonzero write so all active bits extend together.
            if (w_wr && cfg_addr_i == AddrRst && |w_rst_mask) begin
                r_rst <= r_rst | w_rst_mask;
                r_cnt <= CNT_W'(RST_CYCLES);
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) r_rst <= '0;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_wr && cfg_addr_i == AddrFiltCmd && cfg_data_i[0]) begin
                    w_start      = 1'b1;
                    w_state_next = StBusy;
                end
            end
            StBusy: begin
                if (filter_done_i) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= StIdle;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_start <= w_start;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (cfg_addr_i)
            AddrCg:      w_rdata[NB_PERIPH-1:0] = r_cg;
            AddrCfgEvt: begin
                for (int i = 0; i < int'(NB_EVT); i++) begin
                    w_rdata[8*i +: 8] = r_cmp[i];
                end
            end
            AddrRst:      w_rdata[NB_PERIPH-1:0] = r_rst;
            AddrEvtEn:    w_rdata[NB_EVT-1:0]    = r_evt_en;
            AddrEvtStat:  w_rdata[NB_EVT-1:0]    = r_status;
            AddrFiltCmd:  w_rdata[0]             = (r_state == StBusy);
            AddrFiltMode: w_rdata[2:0]           = r_filt_mode;
            default:      w_rdata                = '0;
        endcase
    end

    assign cfg_data_o     = w_rdata;
    assign cfg_ready_o    = 1'b1;
    assign event_ready_o  = 1'b1;
    assign cg_value_o     = r_cg;
    assign cg_core_o      = |r_cg;
    assign rst_value_o    = r_rst;
    assign filter_mode_o  = r_filt_mode;
    assign filter_start_o = r_start;
    assign filter_busy_o  = (r_state == StBusy);
    assign event_o        = r_event;
    assign evt_irq_o      = |r_status;

endmodule

// File: tb/tb_udma_ctrl_gen.sv
// Scoreboard bench for udma_ctrl_gen: stimulus pushes expected values, a negedge
// monitor pops one entry per cfg read or per output probe and compares.
module tb_udma_ctrl_gen;

    localparam int SelRead = 0, SelCg = 1, SelCgCore = 2, SelRst = 3, SelEvt = 4,
                   SelIrq = 5, SelStart = 6, SelBusy = 7, SelCfgRdy = 8, SelEvtRdy = 9,
                   SelMode = 10;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [31:0] cfg_data_i = '0;
    logic [4:0]  cfg_addr_i = '0;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_rwn_i = 1'b0;
    logic [31:0] cfg_data_o;
    logic        cfg_ready_o;
    logic [15:0] cg_value_o;
    logic        cg_core_o;
    logic [15:0] rst_value_o;
    logic [2:0]  filter_mode_o;
    logic        filter_start_o;
    logic        filter_busy_o;
    logic        filter_done_i = 1'b0;
    logic        event_valid_i = 1'b0;
    logic [7:0]  event_data_i = '0;
    logic        event_ready_o;
    logic [3:0]  event_o;
    logic        evt_irq_o;

    udma_ctrl_gen #(
        .NB_PERIPH (16),
        .NB_EVT    (4),
        .RST_CYCLES(8),
        .CNT_W     (8)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .cfg_data_i    (cfg_data_i),
        .cfg_addr_i    (cfg_addr_i),
        .cfg_valid_i   (cfg_valid_i),
        .cfg_rwn_i     (cfg_rwn_i),
        .cfg_data_o    (cfg_data_o),
        .cfg_ready_o   (cfg_ready_o),
        .cg_value_o    (cg_value_o),
        .cg_core_o     (cg_core_o),
        .rst_value_o   (rst_value_o),
        .filter_mode_o (filter_mode_o),
        .filter_start_o(filter_start_o),
        .filter_busy_o (filter_busy_o),
        .filter_done_i (filter_done_i),
        .event_valid_i (event_valid_i),
        .event_data_i  (event_data_i),
        .event_ready_o (event_ready_o),
        .event_o       (event_o),
        .evt_irq_o     (evt_irq_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    logic obs_v = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            SelRead:   return cfg_data_o;
            SelCg:     return 32'(cg_value_o);
            SelCgCore: return 32'(cg_core_o);
            SelRst:    return 32'(rst_value_o);
            SelEvt:    return 32'(event_o);
            SelIrq:    return 32'(evt_irq_o);
            SelStart:  return 32'(filter_start_o);
            SelBusy:   return 32'(filter_busy_o);
            SelCfgRdy: return 32'(cfg_ready_o);
            SelEvtRdy: return 32'(event_ready_o);
            SelMode:   return 32'(filter_mode_o);
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: one scoreboard entry per read strobe or probe strobe.
    always @(negedge clk_i) begin
        if ((cfg_valid_i && cfg_rwn_i) || obs_v) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_empty: output presented with no expected entry");
            end else begin
                m_e = sb.pop_front();
                if (pick(m_e.sel) !== m_e.exp) begin
                    n_err++;
                    $display("FAIL %s: got 0x%08h, expected 0x%08h",
                             m_e.name, pick(m_e.sel), m_e.exp);
                end
            end
        end
    end

    // All tasks start and end at posedge + 1.
    task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
        cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = a; cfg_data_i = d;
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b0;
    endtask

    task automatic cfg_read(input logic [4:0] a, input logic [31:0] e, input string n);
        sb.push_back('{SelRead, e, n});
        cfg_valid_i = 1'b1; cfg_rwn_i = 1'b1; cfg_addr_i = a;
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b0; cfg_rwn_i = 1'b0;
    endtask

    task automatic probe(input int sel, input logic [31:0] e, input string n);
        sb.push_back('{sel, e, n});
        obs_v = 1'b1;
        @(posedge clk_i); #1;
        obs_v = 1'b0;
    endtask

    task automatic send_evt(input logic [7:0] id);
        event_valid_i = 1'b1; event_data_i = id;
        @(posedge clk_i); #1;
        event_valid_i = 1'b0;
    endtask

    task automatic pulse_done();
        filter_done_i = 1'b1;
        @(posedge clk_i); #1;
        filter_done_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1; rstn_i = 1'b1;
        @(posedge clk_i); #1;

        // Reset state
        for (int a = 0; a <= 6; a++) cfg_read(5'(a), 32'h0, $sformatf("rst_read_%0d", a));
        cfg_read(5'h1F, 32'h0, "rst_read_1f");
        probe(SelCfgRdy, 32'h1, "cfg_ready");
        probe(SelEvtRdy, 32'h1, "event_ready");
        probe(SelCgCore, 32'h0, "rst_cg_core");
        probe(SelIrq, 32'h0, "rst_irq");
        probe(SelBusy, 32'h0, "rst_busy");

        // Clock gates
        cfg_write(5'h00, 32'h0000_0005);
        probe(SelCg, 32'h5, "cg_value_5");
        probe(SelCgCore, 32'h1, "cg_core_1");
        cfg_write(5'h00, 32'h0);
        probe(SelCgCore, 32'h0, "cg_core_0");
        cfg_write(5'h00, 32'hFFFF_FFFF);
        cfg_read(5'h00, 32'h0000_FFFF, "cg_width_mask");
        cfg_write(5'h1F, 32'h1234_5678);
        cfg_read(5'h1F, 32'h0, "unmapped_read");

        // Soft reset: high for exactly 8 cycles after the write edge
        cfg_write(5'h02, 32'h0000_0003);
        for (int i = 0; i < 8; i++) probe(SelRst, 32'h3, $sformatf("rst_pulse_c%0d", i));
        probe(SelRst, 32'h0, "rst_pulse_end");
        cfg_write(5'h02, 32'h0);
        probe(SelRst, 32'h0, "rst_zero_write");
        // Extend: second write 5 cycles in
        cfg_write(5'h02, 32'h0000_0003);
        for (int i = 0; i < 5; i++) probe(SelRst, 32'h3, $sformatf("rst_ext_a%0d", i));
        cfg_write(5'h02, 32'h0000_0004);
        for (int i = 0; i < 7; i++) probe(SelRst, 32'h7, $sformatf("rst_ext_b%0d", i));
        cfg_read(5'h02, 32'h7, "rst_ext_read");
        probe(SelRst, 32'h0, "rst_ext_end");

        // Events
        cfg_write(5'h01, 32'h4433_2211);
        cfg_read(5'h01, 32'h4433_2211, "cfg_evt_read");
        cfg_write(5'h03, 32'hFF);
        cfg_read(5'h03, 32'hF, "evt_en_mask");
        cfg_write(5'h03, 32'h5);
        send_evt(8'h11);
        probe(SelEvt, 32'h1, "evt_pulse_11");
        cfg_read(5'h04, 32'h1, "status_after_11");
        probe(SelEvt, 32'h0, "evt_pulse_gone");
        probe(SelIrq, 32'h1, "irq_set");
        send_evt(8'h22);
        probe(SelEvt, 32'h0, "evt_disabled_22");
        cfg_read(5'h04, 32'h1, "status_after_22");
        send_evt(8'h33);
        probe(SelEvt, 32'h4, "evt_pulse_33");
        cfg_read(5'h04, 32'h5, "status_after_33");
        // W1C of all bits concurrent with a new 0x11 hit: bit 0 set wins
        cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = 5'h04; cfg_data_i = 32'h5;
        event_valid_i = 1'b1; event_data_i = 8'h11;
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b0; event_valid_i = 1'b0;
        cfg_read(5'h04, 32'h1, "status_set_wins");
        cfg_write(5'h04, 32'h1);
        cfg_read(5'h04, 32'h0, "status_w1c");
        probe(SelIrq, 32'h0, "irq_cleared");

        // Filter mode and handshake
        cfg_write(5'h06, 32'hFF);
        cfg_read(5'h06, 32'h7, "filt_mode_read");
        probe(SelMode, 32'h7, "filt_mode_out");
        cfg_write(5'h05, 32'h1);
        probe(SelStart, 32'h1, "start_pulse");
        probe(SelStart, 32'h0, "start_one_cycle");
        probe(SelBusy, 32'h1, "busy_set");
        cfg_read(5'h05, 32'h1, "filt_cmd_busy");
        cfg_write(5'h05, 32'h1);
        probe(SelStart, 32'h0, "start_ignored_busy");
        pulse_done();
        probe(SelBusy, 32'h0, "busy_cleared");
        cfg_read(5'h05, 32'h0, "filt_cmd_idle");
        pulse_done();
        probe(SelBusy, 32'h0, "done_in_idle");
        cfg_write(5'h05, 32'h1);
        probe(SelStart, 32'h1, "start_pulse_2");
        cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = 5'h05; cfg_data_i = 32'h1;
        filter_done_i = 1'b1;
        @(posedge clk_i); #1;
        cfg_valid_i = 1'b0; filter_done_i = 1'b0;
        probe(SelStart, 32'h0, "done_start_no_pulse");
        probe(SelBusy, 32'h0, "done_start_idle");

        // Async reset mid-operation
        cfg_write(5'h02, 32'h1);
        cfg_write(5'h05, 32'h1);
        probe(SelRst, 32'h1, "pre_areset_rst");
        rstn_i = 1'b0;
        probe(SelRst, 32'h0, "areset_rst");
        probe(SelBusy, 32'h0, "areset_busy");
        cfg_read(5'h00, 32'h0, "areset_read_cg");
        rstn_i = 1'b1;
        for (int i = 0; i < 10; i++) probe(SelRst, 32'h0, $sformatf("post_areset_rst%0d", i));
        cfg_read(5'h05, 32'h0, "post_areset_filt");

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk_i);
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
